// File: rtl/cnn_stream_classifier.sv
// cnn_stream_classifier: streamed KxK conv -> ReLU -> FC -> argmax, one MAC per cycle.
// Optional build macro CNN_SAT_EN selects saturating (vs wrap-around) ACC_W arithmetic.  Rev 1.0
`default_nettype none

module cnn_stream_classifier #(
    parameter int IMG_W   = 28,
    parameter int K       = 5,
    parameter int PIX_W   = 8,
    parameter int WGT_W   = 8,
    parameter int ACC_W   = 24,
    parameter int N_CLASS = 10,
    parameter int CLS_W   = 4
) (
    input  logic                                              CLK,
    input  logic                                              nRST,
    input  logic                                              START,
    input  logic                                              WIN_VALID,
    output logic                                              WIN_READY,
    input  logic [K*K*PIX_W-1:0]                              WIN,
    input  logic [K*K*WGT_W-1:0]                              CONV_W,
    output logic [$clog2((IMG_W-K+1)*(IMG_W-K+1))-1:0]        FW_ADDR,
    input  logic [N_CLASS*WGT_W-1:0]                          FW_DATA,
    output logic                                              DONE,
    output logic [CLS_W-1:0]                                  OUT
);

    localparam int OUT_W  = IMG_W - K + 1;
    localparam int N_FEAT = OUT_W * OUT_W;
    localparam int FA_W   = $clog2(N_FEAT);
    localparam int NTAP   = K * K;
    localparam int TAP_W  = $clog2(NTAP);
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int FCP_W  = ACC_W + WGT_W;
    localparam int BIG_W  = ACC_W + WGT_W + PIX_W + 2;
`ifdef CNN_SAT_EN
    localparam int TERM_W = BIG_W;
`else
    localparam int TERM_W = ACC_W;
`endif

    localparam logic signed [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_WIN = 3'd1,
        S_MAC      = 3'd2,
        S_ACCUM    = 3'd3,
        S_ARGMAX   = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    // Saturating build widens the add so the clamp sees the true sum.
    function automatic logic signed [ACC_W-1:0] add_acc(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [TERM_W-1:0] b
    );
`ifdef CNN_SAT_EN
        logic signed [BIG_W-1:0] s;
        s = BIG_W'(a) + b;
        if (s > BIG_W'(C_MAX))
            add_acc = C_MAX;
        else if (s < BIG_W'(C_MIN))
            add_acc = C_MIN;
        else
            add_acc = s[ACC_W-1:0];
`else
        add_acc = a + b;
`endif
    endfunction

    state_t                    state_q, state_d;
    logic [NTAP*PIX_W-1:0]     win_q, win_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic signed [ACC_W-1:0]   conv_q, conv_d;
    logic signed [ACC_W-1:0]   acc_q [N_CLASS];
    logic signed [ACC_W-1:0]   acc_d [N_CLASS];
    logic [FA_W-1:0]           feat_q, feat_d;
    logic [CLS_W-1:0]          cmp_q, cmp_d;
    logic [CLS_W-1:0]          best_idx_q, best_idx_d;
    logic signed [ACC_W-1:0]   best_val_q, best_val_d;
    logic [CLS_W-1:0]          out_q, out_d;

    logic [PIX_W-1:0]          w_pix;
    logic signed [WGT_W-1:0]   w_wgt;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [TERM_W-1:0]  w_conv_term;
    logic signed [ACC_W-1:0]   w_feat;
    logic signed [TERM_W-1:0]  w_fc_term  [N_CLASS];
    logic signed [ACC_W-1:0]   w_acc_next [N_CLASS];
    logic signed [ACC_W-1:0]   w_cand;
    logic                      w_better;

    assign FW_ADDR = feat_q;
    assign OUT     = out_q;

    always_comb begin
        w_pix = '0;
        w_wgt = '0;
        for (int t = 0; t < NTAP; t++) begin
            if (tap_q == TAP_W'(t)) begin
                w_pix = win_q[t*PIX_W +: PIX_W];
                w_wgt = CONV_W[t*WGT_W +: WGT_W];
            end
        end
    end

    // Pixel is unsigned: a zero MSB keeps it positive in the signed product.
    assign w_prod      = PROD_W'($signed({1'b0, w_pix})) * PROD_W'(w_wgt);
    assign w_conv_term = TERM_W'(w_prod);
    assign w_feat      = conv_q[ACC_W-1] ? '0 : conv_q;

    always_comb begin
        for (int i = 0; i < N_CLASS; i++) begin
            w_fc_term[i]  = TERM_W'(FCP_W'(w_feat) * FCP_W'($signed(FW_DATA[i*WGT_W +: WGT_W])));
            w_acc_next[i] = add_acc(acc_q[i], w_fc_term[i]);
        end
    end

    always_comb begin
        w_cand = acc_q[0];
        for (int i = 0; i < N_CLASS; i++) begin
            if (cmp_q == CLS_W'(i))
                w_cand = acc_q[i];
        end
    end

    assign w_better = (w_cand > best_val_q);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        tap_d      = tap_q;
        conv_d     = conv_q;
        acc_d      = acc_q;
        feat_d     = feat_q;
        cmp_d      = cmp_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        out_d      = out_q;
        WIN_READY  = 1'b0;
        DONE       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    for (int i = 0; i < N_CLASS; i++)
                        acc_d[i] = '0;
                    feat_d  = '0;
                    state_d = S_WAIT_WIN;
                end
            end
            S_WAIT_WIN: begin
                WIN_READY = 1'b1;
                if (WIN_VALID) begin
                    win_d   = WIN;
                    conv_d  = '0;
                    tap_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                conv_d = add_acc(conv_q, w_conv_term);
                tap_d  = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(NTAP - 1))
                    state_d = S_ACCUM;
            end
            S_ACCUM: begin
                acc_d      = w_acc_next;
                best_val_d = w_acc_next[0];
                best_idx_d = '0;
                cmp_d      = CLS_W'(1);
                if (feat_q == FA_W'(N_FEAT - 1)) begin
                    state_d = S_ARGMAX;
                end else begin
                    feat_d  = feat_q + FA_W'(1);
                    state_d = S_WAIT_WIN;
                end
            end
            S_ARGMAX: begin
                if (w_better) begin
                    best_val_d = w_cand;
                    best_idx_d = cmp_q;
                end
                cmp_d = cmp_q + CLS_W'(1);
                // OUT is loaded on the way into FIN so it is already valid while DONE is high.
                if (cmp_q == CLS_W'(N_CLASS - 1)) begin
                    out_d   = w_better ? cmp_q : best_idx_q;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            tap_q      <= '0;
            conv_q     <= '0;
            for (int i = 0; i < N_CLASS; i++)
                acc_q[i] <= '0;
            feat_q     <= '0;
            cmp_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            tap_q      <= tap_d;
            conv_q     <= conv_d;
            acc_q      <= acc_d;
            feat_q     <= feat_d;
            cmp_q      <= cmp_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            out_q      <= out_d;
        end
    end

endmodule

`default_nettype wire
